// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, parity FSM
// states and the parity-bit helper used by RX and TX.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_WAIT_PAR = 2'd2
  } par_state_t;

  // Codes 5..7 are reserved and treated as "no parity".
  function automatic logic par_is_none(input logic [2:0] mode);
    return !(mode inside {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE});
  endfunction

  function automatic logic par_bit(
    input logic       acc,
    input logic [2:0] mode
  );
    logic res;
    res = 1'b0;
    unique case (1'b1)
      (mode == PAR_EVEN):  res = acc;
      (mode == PAR_ODD):   res = ~acc;
      (mode == PAR_MARK):  res = 1'b1;
      (mode == PAR_SPACE): res = 1'b0;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; clear and increment
// in the same cycle restart the count at one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = i_inc ? ONE : '0;
    end else if (i_inc && (count_q != MAX)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/parity_unit.sv
// Bit-serial parity generator / checker for one UART
// frame at a time, with sticky error and error counter.
module parity_unit
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8,
  localparam int CW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [2:0]               i_mode,
  input  logic                     i_start,
  input  logic                     i_bit_valid,
  input  logic                     i_bit,
  input  logic                     i_par_valid,
  input  logic                     i_par_bit,
  input  logic                     i_err_clr,
  output logic                     o_busy,
  output logic                     o_gen_valid,
  output logic                     o_gen_bit,
  output logic                     o_chk_valid,
  output logic                     o_chk_err,
  output logic                     o_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic [CW-1:0]            o_bit_count
);

  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  par_state_t    state_q,   state_d;
  logic [2:0]    mode_q,    mode_d;
  logic          acc_q,     acc_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          gvalid_q,  gvalid_d;
  logic          gbit_q,    gbit_d;
  logic          cvalid_q,  cvalid_d;
  logic          cerr_q,    cerr_d;
  logic          sticky_q,  sticky_d;
  logic          acc_nxt;
  logic          mismatch;

  assign acc_nxt = acc_q ^ i_bit;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    gvalid_d = gvalid_q;
    gbit_d   = gbit_q;
    cvalid_d = 1'b0;
    cerr_d   = 1'b0;
    if (i_start) begin
      // Restart wins over everything, silently dropping any frame.
      state_d  = ST_ACCUM;
      mode_d   = i_mode;
      acc_d    = 1'b0;
      cnt_d    = '0;
      gvalid_d = 1'b0;
      gbit_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (i_bit_valid) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + ONE;
            if (cnt_q == LAST) begin
              if (par_is_none(mode_q)) begin
                state_d  = ST_IDLE;
                cvalid_d = 1'b1;
              end else begin
                state_d  = ST_WAIT_PAR;
                gvalid_d = 1'b1;
                gbit_d   = par_bit(acc_nxt, mode_q);
              end
            end
          end
        end
        ST_WAIT_PAR: begin
          if (i_par_valid) begin
            state_d  = ST_IDLE;
            cvalid_d = 1'b1;
            cerr_d   = (i_par_bit != gbit_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign mismatch = cvalid_d && cerr_d;

  always_comb begin
    sticky_d = sticky_q;
    if (mismatch) begin
      sticky_d = 1'b1;
    end else if (i_err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= PAR_NONE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      gvalid_q <= 1'b0;
      gbit_q   <= 1'b0;
      cvalid_q <= 1'b0;
      cerr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      gvalid_q <= gvalid_d;
      gbit_q   <= gbit_d;
      cvalid_q <= cvalid_d;
      cerr_q   <= cerr_d;
      sticky_q <= sticky_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (mismatch),
    .i_clr   (i_err_clr),
    .o_count (o_err_count)
  );

  assign o_busy       = (state_q != ST_IDLE);
  assign o_gen_valid  = gvalid_q;
  assign o_gen_bit    = gbit_q;
  assign o_chk_valid  = cvalid_q;
  assign o_chk_err    = cerr_q;
  assign o_err_sticky = sticky_q;
  assign o_bit_count  = cnt_q;

endmodule

// File: tb/tb_parity_unit.sv
// Directed bench for parity_unit: default instance plus
// a 2-bit error counter instance for saturation.
module tb_parity_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       start, bit_valid, sbit;
  logic       par_valid, par_in, err_clr;

  logic       busy, gvalid, gbit, cvalid, cerr, sticky;
  logic [7:0] ecount;
  logic [3:0] bcount;

  logic       s_busy, s_gvalid, s_gbit, s_cvalid, s_cerr, s_sticky;
  logic [1:0] s_ecount;
  logic [3:0] s_bcount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_unit u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mode       (mode),
    .i_start      (start),
    .i_bit_valid  (bit_valid),
    .i_bit        (sbit),
    .i_par_valid  (par_valid),
    .i_par_bit    (par_in),
    .i_err_clr    (err_clr),
    .o_busy       (busy),
    .o_gen_valid  (gvalid),
    .o_gen_bit    (gbit),
    .o_chk_valid  (cvalid),
    .o_chk_err    (cerr),
    .o_err_sticky (sticky),
    .o_err_count  (ecount),
    .o_bit_count  (bcount)
  );

  parity_unit #(.ERR_CNT_WIDTH(2)) u_small (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mode       (mode),
    .i_start      (start),
    .i_bit_valid  (bit_valid),
    .i_bit        (sbit),
    .i_par_valid  (par_valid),
    .i_par_bit    (par_in),
    .i_err_clr    (err_clr),
    .o_busy       (s_busy),
    .o_gen_valid  (s_gvalid),
    .o_gen_bit    (s_gbit),
    .o_chk_valid  (s_cvalid),
    .o_chk_err    (s_cerr),
    .o_err_sticky (s_sticky),
    .o_err_count  (s_ecount),
    .o_bit_count  (s_bcount)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [2:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      sbit      = d[i];
      tick();
      bit_valid = 1'b0;
      if (gaps && i[0]) begin
        tick();
        chk("abort_no_chk", cvalid, 0);
      end
    end
  endtask

  task automatic send_par(input logic p);
    par_valid = 1'b1;
    par_in    = p;
    tick();
    par_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 3'd0; start = 0; bit_valid = 0; sbit = 0;
    par_valid = 0; par_in = 0; err_clr = 0;
    #3;
    chk("rst_busy",   busy,   0);
    chk("rst_gvalid", gvalid, 0);
    chk("rst_cvalid", cvalid, 0);
    chk("rst_count",  ecount, 0);
    chk("rst_bcount", bcount, 0);
    rst = 1'b0;
    tick();

    // even parity of 0xA5 (four ones) is 0
    start_frame(3'd1);
    chk("even_busy", busy, 1);
    send_bits(8'hA5, 8, 0);
    chk("even_gvalid", gvalid, 1);
    chk("even_gbit",   gbit,   0);
    chk("even_bcount", bcount, 8);
    send_par(1'b0);
    chk("even_cvalid", cvalid, 1);
    chk("even_cerr",   cerr,   0);
    chk("even_count",  ecount, 0);
    chk("even_idle",   busy,   0);
    tick();
    chk("even_pulse",  cvalid, 0);
    chk("even_hold",   gvalid, 1);

    // odd parity of 0xA5 is 1; received 0 is a mismatch
    start_frame(3'd2);
    send_bits(8'hA5, 8, 0);
    chk("odd_gbit", gbit, 1);
    send_par(1'b0);
    chk("odd_cvalid", cvalid, 1);
    chk("odd_cerr",   cerr,   1);
    chk("odd_sticky", sticky, 1);
    chk("odd_count",  ecount, 1);

    // no parity: check completes one cycle after the 8th bit
    start_frame(3'd0);
    send_bits(8'hFF, 7, 0);
    chk("none_pre", cvalid, 0);
    bit_valid = 1'b1; sbit = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("none_cvalid", cvalid, 1);
    chk("none_cerr",   cerr,   0);
    chk("none_gvalid", gvalid, 0);
    chk("none_idle",   busy,   0);
    send_par(1'b0);
    chk("none_late_par", cvalid, 0);
    chk("none_count",    ecount, 1);

    // abort after 3 bits, then 0x07 with idle gaps
    start_frame(3'd1);
    send_bits(8'h07, 3, 0);
    chk("abort_bc3", bcount, 3);
    start_frame(3'd1);
    chk("abort_cvalid", cvalid, 0);
    chk("abort_bc0",    bcount, 0);
    send_bits(8'h07, 8, 1);
    chk("gap_bcount", bcount, 8);
    chk("gap_gvalid", gvalid, 1);
    chk("gap_gbit",   gbit,   1);

    // saturation on the 2-bit counter, mark mode
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr0_small",  s_ecount, 0);
    chk("clr0_sticky", s_sticky, 0);
    for (int f = 0; f < 5; f++) begin
      start_frame(3'd3);
      send_bits(8'h3C, 8, 0);
      send_par(1'b0);
    end
    chk("sat_gbit",   s_gbit,   1);
    chk("sat_small",  s_ecount, 3);
    chk("sat_sticky", s_sticky, 1);
    chk("sat_main",   ecount,   5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_small",  s_ecount, 0);
    chk("clr_sticky", s_sticky, 0);
    chk("clr_main",   ecount,   0);
    start_frame(3'd3);
    send_bits(8'h00, 8, 0);
    err_clr = 1'b1;
    send_par(1'b0);
    err_clr = 1'b0;
    chk("coinc_small",  s_ecount, 1);
    chk("coinc_sticky", s_sticky, 1);
    chk("coinc_main",   ecount,   1);

    // reset between edges in the middle of a frame
    start_frame(3'd1);
    send_bits(8'hFF, 3, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy",   busy,   0);
    chk("mrst_bcount", bcount, 0);
    chk("mrst_sticky", sticky, 0);
    chk("mrst_count",  ecount, 0);
    chk("mrst_gvalid", gvalid, 0);
    #2;
    rst = 1'b0;
    tick();
    start_frame(3'd1);
    send_bits(8'h01, 8, 0);
    chk("post_gbit", gbit, 1);
    send_par(1'b1);
    chk("post_cvalid", cvalid, 1);
    chk("post_cerr",   cerr,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_unit.md
Name: parity_unit

Overview:
- Bit-serial parity generator and checker for the UART datapath.
- Sits beside the TX/RX shift registers and sees each data bit as it is shifted.
- Produces the parity bit to transmit, or checks a received parity bit, for one frame at a time.
- Adds runtime parity-mode selection, configurable data width, per-frame handshakes, a sticky error flag and a saturating error counter.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- ERR_CNT_WIDTH, 8, width of the saturating parity-error counter; minimum 1.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_mode  in  3  parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 behave as none. Sampled only on i_start.
- i_start  in  1  one-cycle pulse that begins a frame.
- i_bit_valid  in  1  i_bit carries the next data bit, LSB first.
- i_bit  in  1  serial data bit.
- i_par_valid  in  1  i_par_bit carries the received parity bit.
- i_par_bit  in  1  received parity bit.
- i_err_clr  in  1  clears o_err_sticky and o_err_count.
- o_busy  out  1  high outside IDLE.
- o_gen_valid  out  1  o_gen_bit is valid (level).
- o_gen_bit  out  1  generated parity bit.
- o_chk_valid  out  1  one-cycle pulse: frame check complete.
- o_chk_err  out  1  qualified by o_chk_valid: parity mismatch.
- o_err_sticky  out  1  set on any mismatch; held until cleared.
- o_err_count  out  ERR_CNT_WIDTH  saturating mismatch count.
- o_bit_count  out  $clog2(DATA_WIDTH+1)  data bits accumulated in the current frame.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator 0, latched mode 0.
- States: IDLE, ACCUM, WAIT_PAR.
- i_start in any state:
  - Latches i_mode, clears the accumulator, o_bit_count, o_gen_valid and o_gen_bit, then enters ACCUM.
  - A frame in progress is aborted silently (no o_chk_valid).
  - i_bit_valid in the same cycle as i_start is ignored.
- ACCUM:
  - Each i_bit_valid XORs i_bit into the accumulator and increments o_bit_count.
  - i_par_valid is ignored.
  - When the DATA_WIDTH-th bit is sampled, the next cycle shows o_bit_count=DATA_WIDTH and one of:
    - Mode none: go to IDLE; o_chk_valid=1, o_chk_err=0; o_gen_valid stays 0.
    - Any other mode: go to WAIT_PAR; o_gen_valid=1.
- o_gen_bit by mode: even = XOR of the data; odd = inverted XOR; mark = 1; space = 0.
- o_gen_valid and o_gen_bit hold through WAIT_PAR and IDLE until the next i_start or reset.
- WAIT_PAR:
  - i_bit_valid is ignored.
  - On i_par_valid: next cycle o_chk_valid=1 and o_chk_err=(i_par_bit != o_gen_bit); go to IDLE.
  - The TX side never drives i_par_valid and restarts with i_start.
- IDLE: i_bit_valid and i_par_valid are ignored.
- Error accounting:
  - A mismatch sets o_err_sticky and increments o_err_count, saturating at all-ones (no wrap).
  - Both update in the same cycle o_chk_valid asserts.
  - i_err_clr alone clears both next cycle.
  - i_err_clr coincident with a mismatch update: result is sticky=1, count=1.
- Reset mid-frame returns everything to reset values immediately, regardless of clock.
- Latency:
  - 1 cycle from the last data bit to o_gen_valid.
  - 1 cycle from i_par_valid to o_chk_valid.
  - A frame can complete with back-to-back valids every cycle.

Decomposition:
- Shared package uart_pkg:
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE (3 bits).
  - State encodings for parity_unit.
  - A parity-bit function (accumulator, mode) reused by the TX path.
- One sub-module, sat_counter: ERR_CNT_WIDTH-wide saturating counter with increment and clear; clear then increment within one cycle yields 1.

Test Plan:
- Even mode, bits of 0xA5 LSB first, one per cycle -> o_gen_valid=1, o_gen_bit=0. i_par_bit=0 -> o_chk_valid pulse, o_chk_err=0, count stays 0.
- Odd mode, 0xA5, i_par_bit=0 -> o_gen_bit=1, o_chk_err=1, o_err_sticky=1, o_err_count=1.
- Mode none, 0xFF -> o_chk_valid exactly one cycle after the 8th bit, o_chk_err=0, o_gen_valid=0. A later i_par_valid has no effect.
- Abort and gaps: even mode, 3 bits, then i_start and bits of 0x07 with idle gaps -> no o_chk_valid for the aborted frame; o_bit_count reaches 8; o_gen_bit=1.
- Saturation: ERR_CNT_WIDTH=2, mark mode, five frames with i_par_bit=0 -> o_err_count=3, sticky=1. i_err_clr -> both 0. Clear coincident with a mismatch -> count=1.
- Reset asserted mid-ACCUM, between clock edges -> all outputs 0 immediately. After release, a fresh even-mode 0x01 frame -> o_gen_bit=1.
